// File: rtl/pc_predict_unit_pkg.sv
// Local types for the PC predictor: return-resolution state.
package pc_predict_unit_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_RET_WAIT = 1'b1
  } ret_state_e;

endpackage

// File: rtl/y86_pkg.sv
// Shared Y86 instruction encodings used across the fetch/decode pipeline.
package y86_pkg;

  localparam int unsigned ICODE_W = 4;

  localparam logic [ICODE_W-1:0] IHALT = 4'h0;
  localparam logic [ICODE_W-1:0] IJXX  = 4'h7;
  localparam logic [ICODE_W-1:0] ICALL = 4'h8;
  localparam logic [ICODE_W-1:0] IRET  = 4'h9;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry
// and latches a sticky overflow flag.
module ras_stack #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [ADDR_W-1:0]       data_i,
  output logic [ADDR_W-1:0]       top_c_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d, top_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  // sp points at the next free slot; when full that slot holds the oldest entry
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push_i) begin
      sp_d = sp_q + PTR_W'(1);
      if (cnt_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_i && (cnt_q != '0)) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[sp_q] <= data_i;
    end
  end

  assign top_idx    = sp_q - PTR_W'(1);
  assign top_c_o    = mem_q[top_idx];
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC predictor: predict-taken jumps, RAS-based return prediction, and
// redirect on mispredict / ret resolution. RAS present only with PC_PREDICT_RAS_EN.
module pc_predict_unit
  import y86_pkg::*;
  import pc_predict_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 64,
  parameter int unsigned        RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        f_valid,
  input  logic [ICODE_W-1:0]          f_icode,
  input  logic [ADDR_W-1:0]           f_valC,
  input  logic [ADDR_W-1:0]           f_valP,
  input  logic                        e_mispredict,
  input  logic [ADDR_W-1:0]           e_valP,
  input  logic                        m_ret_valid,
  input  logic [ADDR_W-1:0]           m_valM,
  output logic [ADDR_W-1:0]           pc,
  output logic                        ret_pending,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow
);

  ret_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pred_q, pred_d;
  logic              pred_vld_q, pred_vld_d;

`ifdef PC_PREDICT_RAS_EN
  logic                       ras_push, ras_pop, ras_empty;
  logic [ADDR_W-1:0]          ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_cnt;

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .data_i     (f_valP),
    .top_c_o    (ras_top),
    .count_o    (ras_cnt),
    .overflow_o (ras_overflow)
  );

  assign ras_empty = (ras_cnt == '0);
  assign ras_count = ras_cnt;
`else
  assign ras_count    = '0;
  assign ras_overflow = 1'b0;
`endif

  // Priority: mispredict > ret resolution > stall > fetch prediction
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pred_d     = pred_q;
    pred_vld_d = pred_vld_q;
`ifdef PC_PREDICT_RAS_EN
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
`endif
    if (e_mispredict) begin
      pc_d    = e_valP;
      state_d = ST_RUN;
    end else if (m_ret_valid && (state_q == ST_RET_WAIT)) begin
      state_d = ST_RUN;
      if (!pred_vld_q || (m_valM != pred_q)) begin
        pc_d = m_valM;
      end
    end else if (!stall && f_valid) begin
      case (f_icode)
        IJXX:  pc_d = f_valC;
        ICALL: begin
          pc_d = f_valC;
`ifdef PC_PREDICT_RAS_EN
          ras_push = 1'b1;
`endif
        end
        IRET: begin
          // A second ret while one is unresolved is held off entirely
          if (state_q == ST_RUN) begin
            state_d    = ST_RET_WAIT;
            pred_vld_d = 1'b0;
`ifdef PC_PREDICT_RAS_EN
            if (!ras_empty) begin
              pc_d       = ras_top;
              pred_d     = ras_top;
              pred_vld_d = 1'b1;
              ras_pop    = 1'b1;
            end
`endif
          end
        end
        IHALT:   pc_d = pc_q;
        default: pc_d = f_valP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pred_q     <= '0;
      pred_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pred_q     <= pred_d;
      pred_vld_q <= pred_vld_d;
    end
  end

  assign pc          = pc_q;
  assign ret_pending = (state_q == ST_RET_WAIT);

endmodule

// File: doc/pc_predict_unit.md
PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, PC/address width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries, power of two, minimum 2.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port stall  input  1  fetch stall; hold PC and RAS.
REQ-007 SHALL have port f_valid  input  1  fetched instruction valid this cycle.
REQ-008 SHALL have port f_icode  input  4  fetched icode (Y86 encoding).
REQ-009 SHALL have port f_valC  input  ADDR_W  fetched constant or destination.
REQ-010 SHALL have port f_valP  input  ADDR_W  fall-through address.
REQ-011 SHALL have port e_mispredict  input  1  execute stage: jxx predicted taken was not taken.
REQ-012 SHALL have port e_valP  input  ADDR_W  correct fall-through for the mispredicted jxx.
REQ-013 SHALL have port m_ret_valid  input  1  memory stage resolved a ret.
REQ-014 SHALL have port m_valM  input  ADDR_W  actual return address.
REQ-015 SHALL have port pc  output  ADDR_W  current fetch PC.
REQ-016 SHALL have port ret_pending  output  1  a ret is in flight; upstream stalls fetch.
REQ-017 SHALL have port ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
REQ-018 SHALL have port ras_overflow  output  1  sticky flag; a push overwrote an entry.

Function
REQ-019 SHALL register pc; every change is visible one cycle after the deciding edge; no combinational input-to-pc path.
REQ-020 SHALL apply, when f_valid and not stall, the following: jxx (7) -> f_valC (predict taken); call (8) -> f_valC, push f_valP; ret (9) -> pop top, set ret_pending, record prediction; halt (0) -> hold pc; any other icode -> f_valP.
REQ-021 SHALL use the priority rst > e_mispredict > ret redirect > stall > prediction.
REQ-022 SHALL load pc = e_valP on e_mispredict, clear ret_pending, and leave RAS contents unrepaired.
REQ-023 SHALL, on m_ret_valid with ret_pending set, clear ret_pending; if m_valM differs from the recorded prediction, or no prediction was made, load pc = m_valM; otherwise leave pc unchanged.
REQ-024 SHALL treat a ret fetched while ret_pending as stalled: no pop and pc held.
REQ-025 SHALL, on a pop from an empty RAS, make no prediction, hold pc, set ret_pending, and wait for m_valM.
REQ-026 SHALL implement the RAS as circular; a push when full overwrites the oldest entry, keeps ras_count = RAS_DEPTH, and sets ras_overflow.
REQ-027 SHALL ignore m_ret_valid when ret_pending is clear.
REQ-028 SHALL make pc wrap modulo 2^ADDR_W; no overflow detection.

Reset
REQ-029 SHALL, on rst, set pc = RESET_PC, ret_pending = 0, ras_count = 0, ras_overflow = 0; RAS contents don't-care; rst overrides every input in the same cycle, including mid-ret.

Configuration
REQ-030 SHALL, with PC_PREDICT_RAS_EN defined, include the RAS as specified.
REQ-031 SHALL, without PC_PREDICT_RAS_EN, contain no RAS: a ret always follows the empty-RAS path of REQ-025, call pushes nothing, ras_count ties to 0, and ras_overflow ties to 0.

Structure
REQ-032 SHALL take icode constants (IHALT, IJXX, ICALL, IRET) from the shared y86_pkg, with no local literals.
REQ-033 SHALL place the RAS in sub-module ras_stack (push, pop, top, count, overflow), instantiated only under PC_PREDICT_RAS_EN.

Verification
REQ-034 SHALL cover: reset with RESET_PC=0x100 -> pc=0x100, ras_count=0, ret_pending=0.
REQ-035 SHALL cover: call valC=0x400, valP=0x20A, then ret, then m_valM=0x20A -> pc 0x400, then 0x20A, no redirect, ret_pending clears.
REQ-036 SHALL cover: jxx valC=0x80 followed by e_mispredict with e_valP=0x3A in the same cycle as f_valid -> pc=0x3A, since mispredict wins.
REQ-037 SHALL cover: RAS_DEPTH=4, five calls, then five rets -> ras_overflow=1; the fifth ret finds the RAS empty, ret_pending is held, and pc loads m_valM.
REQ-038 SHALL cover: ret predicted 0x20A, m_valM=0x300 -> pc=0x300 next cycle; rst asserted while ret_pending -> REQ-029 state.
REQ-039 SHALL cover: build without PC_PREDICT_RAS_EN, call then ret -> ret holds pc until m_ret_valid, and ras_count stays 0.
